// File: rtl/inexrecur_pkg.sv
// Shared definitions for the InexRecur parameter queue.
//   FIELD_W / NUM_FIELDS / DATA_W : default entry geometry ({i,z,k,l} tuple)
//   inexrecur_entry_t             : packed view of one stored tuple
//   SRC_SEQ / SRC_RAN             : r_src encodings (sequential pop / random read)
//   MODE_FIFO / MODE_LIFO         : sequential ordering selector values
package inexrecur_pkg;

  localparam int unsigned FIELD_W    = 8;
  localparam int unsigned NUM_FIELDS = 4;
  localparam int unsigned DATA_W     = FIELD_W * NUM_FIELDS;

  // Field i occupies the most significant bits, l the least significant.
  typedef struct packed {
    logic [FIELD_W-1:0] i;
    logic [FIELD_W-1:0] z;
    logic [FIELD_W-1:0] k;
    logic [FIELD_W-1:0] l;
  } inexrecur_entry_t;

  localparam logic SRC_SEQ = 1'b0;
  localparam logic SRC_RAN = 1'b1;

  localparam int unsigned MODE_FIFO = 0;
  localparam int unsigned MODE_LIFO = 1;

endpackage

// File: rtl/regfile_dp_mem.sv
// Storage array for the InexRecur queue: two write ports, one synchronous read port.
//   clk, rst_n          : clock, async active-low reset (read register only)
//   a_we/a_addr/a_data  : full-entry write port (sequential push)
//   b_we/b_fe/b_addr/b_data : per-field write port (random write)
//   rd_en/rd_addr       : read request
//   rd_data             : registered read data, holds between reads
// Read-first: a read and a write to the same address in one cycle return the old
// contents. If both write ports hit the same address, port A takes effect.
// Array contents are not reset.
module regfile_dp_mem #(
  parameter int unsigned FIELD_W    = 8,
  parameter int unsigned NUM_FIELDS = 4,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_W     = 12,
  localparam int unsigned DATA_W    = FIELD_W * NUM_FIELDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_we,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_we,
  input  logic [NUM_FIELDS-1:0] b_fe,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Port A is written last so it overrides port B on a shared address.
  always_ff @(posedge clk) begin
    for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
      if (b_we && b_fe[f]) begin
        mem_q[b_addr][f*FIELD_W +: FIELD_W] <= b_data[f*FIELD_W +: FIELD_W];
      end
    end
    if (a_we) begin
      mem_q[a_addr] <= a_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/regfile_inexrecur_queue.sv
// InexRecur parameter store: {i,z,k,l} tuples with a sequential (FIFO or LIFO)
// side and a physically addressed random side.
//   seq_we/seq_w_data/seq_re        : push / pop
//   ran_we/ran_w_addr/ran_w_data    : random write
//   ran_re/ran_r_addr/ran_ready     : random read request, accepted when ran_ready
//   r_valid/r_src/r_addr/r_data     : registered read result (1-cycle latency)
//   count/full/empty                : occupancy
//   ovf/udf                         : sticky push-while-full / pop-while-empty
//   ran_w_drop                      : random write lost to a same-address push
// Optional feature macro INEXRECUR_FIELD_WE_EN adds ran_w_fe (per-field random
// write enables); without it random writes update the whole entry.
module regfile_inexrecur_queue
  import inexrecur_pkg::*;
#(
  parameter int unsigned FIELD_W    = inexrecur_pkg::FIELD_W,
  parameter int unsigned NUM_FIELDS = inexrecur_pkg::NUM_FIELDS,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_W     = $clog2(DEPTH),
  parameter int unsigned MODE       = MODE_FIFO,
  localparam int unsigned DATA_W    = FIELD_W * NUM_FIELDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seq_we,
  input  logic [DATA_W-1:0]     seq_w_data,
  input  logic                  seq_re,
  input  logic                  ran_we,
  input  logic [ADDR_W-1:0]     ran_w_addr,
  input  logic [DATA_W-1:0]     ran_w_data,
`ifdef INEXRECUR_FIELD_WE_EN
  input  logic [NUM_FIELDS-1:0] ran_w_fe,
`endif
  input  logic                  ran_re,
  input  logic [ADDR_W-1:0]     ran_r_addr,
  output logic                  ran_ready,
  output logic                  r_valid,
  output logic                  r_src,
  output logic [ADDR_W-1:0]     r_addr,
  output logic [DATA_W-1:0]     r_data,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  udf,
  output logic                  ran_w_drop
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              r_valid_q, r_valid_d;
  logic              r_src_q, r_src_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              drop_q, drop_d;

  logic              empty_w, full_w;
  logic              pop_ok, push_ok, ran_acc;
  logic [ADDR_W-1:0] sp, sp_m1;
  logic [ADDR_W-1:0] pop_addr, push_addr, rd_addr;
  logic              rd_en;
  logic              ran_hit, ran_we_eff;
  logic [NUM_FIELDS-1:0] fe;

`ifdef INEXRECUR_FIELD_WE_EN
  assign fe = ran_w_fe;
`else
  assign fe = '1;
`endif

  always_comb begin
    empty_w   = (count_q == '0);
    full_w    = (count_q == DEPTH_C);
    pop_ok    = seq_re && !empty_w;
    // A pop in the same cycle frees a slot, so push+pop is legal when full.
    push_ok   = seq_we && (!full_w || pop_ok);
    ran_ready = !seq_re || empty_w;
    ran_acc   = ran_re && ran_ready;

    // In LIFO order the stack pointer equals the occupancy count.
    sp    = count_q[ADDR_W-1:0];
    sp_m1 = sp - 1'b1;

    if (MODE == MODE_LIFO) begin
      pop_addr  = sp_m1;
      // Push+pop replaces the top entry in place; read-first returns the old one.
      push_addr = pop_ok ? sp_m1 : sp;
    end else begin
      pop_addr  = rd_ptr_q;
      push_addr = wr_ptr_q;
    end

    rd_en   = pop_ok || ran_acc;
    rd_addr = pop_ok ? pop_addr : ran_r_addr;

    ran_hit    = ran_we && push_ok && (ran_w_addr == push_addr);
    ran_we_eff = ran_we && !ran_hit;

    wr_ptr_d = wr_ptr_q + ADDR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop_ok);
    count_d  = count_q + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);

    r_valid_d = rd_en;
    r_src_d   = r_src_q;
    r_addr_d  = r_addr_q;
    if (pop_ok) begin
      r_src_d  = SRC_SEQ;
      r_addr_d = pop_addr;
    end else if (ran_acc) begin
      r_src_d  = SRC_RAN;
      r_addr_d = ran_r_addr;
    end

    ovf_d  = ovf_q || (seq_we && full_w && !pop_ok);
    udf_d  = udf_q || (seq_re && empty_w);
    drop_d = ran_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      r_valid_q <= 1'b0;
      r_src_q   <= 1'b0;
      r_addr_q  <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      r_valid_q <= r_valid_d;
      r_src_q   <= r_src_d;
      r_addr_q  <= r_addr_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      drop_q    <= drop_d;
    end
  end

  regfile_dp_mem #(
    .FIELD_W    (FIELD_W),
    .NUM_FIELDS (NUM_FIELDS),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_we    (push_ok),
    .a_addr  (push_addr),
    .a_data  (seq_w_data),
    .b_we    (ran_we_eff),
    .b_fe    (fe),
    .b_addr  (ran_w_addr),
    .b_data  (ran_w_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (r_data)
  );

  assign r_valid    = r_valid_q;
  assign r_src      = r_src_q;
  assign r_addr     = r_addr_q;
  assign count      = count_q;
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign ovf        = ovf_q;
  assign udf        = udf_q;
  assign ran_w_drop = drop_q;

endmodule

// File: tb/tb_regfile_inexrecur_queue.sv
// Directed scoreboard bench: one FIFO and one LIFO instance (DEPTH=16).
module tb_regfile_inexrecur_queue;
  import inexrecur_pkg::*;

  localparam int unsigned NF    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // FIFO instance signals
  logic          f_swe, f_sre, f_rwe, f_rre;
  logic [DW-1:0] f_swd, f_rwd;
  logic [AW-1:0] f_rwa, f_rra;
  logic          f_rdy, f_rv, f_rs, f_full, f_empty, f_ovf, f_udf, f_drop;
  logic [AW-1:0] f_ra;
  logic [DW-1:0] f_rd;
  logic [AW:0]   f_cnt;
  // LIFO instance signals
  logic          l_swe, l_sre, l_rwe, l_rre;
  logic [DW-1:0] l_swd, l_rwd;
  logic [AW-1:0] l_rwa, l_rra;
  logic          l_rdy, l_rv, l_rs, l_full, l_empty, l_ovf, l_udf, l_drop;
  logic [AW-1:0] l_ra;
  logic [DW-1:0] l_rd;
  logic [AW:0]   l_cnt;
`ifdef INEXRECUR_FIELD_WE_EN
  logic [NF-1:0] f_fe, l_fe;
`endif

  regfile_inexrecur_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .MODE(MODE_FIFO)) dut_f (
    .clk(clk), .rst_n(rst_n), .seq_we(f_swe), .seq_w_data(f_swd), .seq_re(f_sre),
    .ran_we(f_rwe), .ran_w_addr(f_rwa), .ran_w_data(f_rwd),
`ifdef INEXRECUR_FIELD_WE_EN
    .ran_w_fe(f_fe),
`endif
    .ran_re(f_rre), .ran_r_addr(f_rra), .ran_ready(f_rdy), .r_valid(f_rv), .r_src(f_rs),
    .r_addr(f_ra), .r_data(f_rd), .count(f_cnt), .full(f_full), .empty(f_empty),
    .ovf(f_ovf), .udf(f_udf), .ran_w_drop(f_drop));

  regfile_inexrecur_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .MODE(MODE_LIFO)) dut_l (
    .clk(clk), .rst_n(rst_n), .seq_we(l_swe), .seq_w_data(l_swd), .seq_re(l_sre),
    .ran_we(l_rwe), .ran_w_addr(l_rwa), .ran_w_data(l_rwd),
`ifdef INEXRECUR_FIELD_WE_EN
    .ran_w_fe(l_fe),
`endif
    .ran_re(l_rre), .ran_r_addr(l_rra), .ran_ready(l_rdy), .r_valid(l_rv), .r_src(l_rs),
    .r_addr(l_ra), .r_data(l_rd), .count(l_cnt), .full(l_full), .empty(l_empty),
    .ovf(l_ovf), .udf(l_udf), .ran_w_drop(l_drop));

  typedef struct packed {
    logic          src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rd_t;

  rd_t q_f[$];
  rd_t q_l[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_swe = 0; f_sre = 0; f_rwe = 0; f_rre = 0;
    f_swd = '0; f_rwd = '0; f_rwa = '0; f_rra = '0;
    l_swe = 0; l_sre = 0; l_rwe = 0; l_rre = 0;
    l_swd = '0; l_rwd = '0; l_rwa = '0; l_rra = '0;
`ifdef INEXRECUR_FIELD_WE_EN
    f_fe = '1; l_fe = '1;
`endif
  endtask

  // Output monitor: every returned read must match the oldest expected entry.
  always @(negedge clk) begin : mon
    rd_t e;
    if (rst_n) begin
      if (f_rv) begin
        if (q_f.size() == 0) chk("f_unexpected_rvalid", f_rv, 0);
        else begin
          e = q_f.pop_front();
          chk("f_r_src", f_rs, e.src);
          chk("f_r_addr", f_ra, e.addr);
          chk("f_r_data", f_rd, e.data);
        end
      end
      if (l_rv) begin
        if (q_l.size() == 0) chk("l_unexpected_rvalid", l_rv, 0);
        else begin
          e = q_l.pop_front();
          chk("l_r_src", l_rs, e.src);
          chk("l_r_addr", l_ra, e.addr);
          chk("l_r_data", l_rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    chk("f_cnt_rst", f_cnt, 0);
    chk("f_empty_rst", f_empty, 1);
    chk("f_full_rst", f_full, 0);
    chk("f_rvalid_rst", f_rv, 0);
    chk("f_rdata_rst", f_rd, 0);
    chk("f_ovf_rst", f_ovf, 0);
    chk("f_udf_rst", f_udf, 0);
    chk("l_cnt_rst", l_cnt, 0);
    chk("l_drop_rst", l_drop, 0);

    // FIFO order
    f_swe = 1; f_swd = 32'h01020304; tick();
    f_swd = 32'h05060708; tick();
    f_swe = 0;
    chk("f_cnt_2", f_cnt, 2);
    f_sre = 1;
    q_f.push_back(rd_t'{SRC_SEQ, 4'd0, 32'h01020304}); tick();
    q_f.push_back(rd_t'{SRC_SEQ, 4'd1, 32'h05060708}); tick();
    f_sre = 0;
    chk("f_empty_after_pops", f_empty, 1);

    // LIFO order
    l_swe = 1; l_swd = 32'hA0A0A0A0; tick();
    l_swd = 32'hB1B1B1B1; tick();
    l_swd = 32'hC2C2C2C2; tick();
    l_swe = 0;
    chk("l_cnt_3", l_cnt, 3);
    l_sre = 1;
    q_l.push_back(rd_t'{SRC_SEQ, 4'd2, 32'hC2C2C2C2}); tick();
    chk("l_cnt_2", l_cnt, 2);
    q_l.push_back(rd_t'{SRC_SEQ, 4'd1, 32'hB1B1B1B1}); tick();
    q_l.push_back(rd_t'{SRC_SEQ, 4'd0, 32'hA0A0A0A0}); tick();
    l_sre = 0;
    chk("l_cnt_0", l_cnt, 0);

    // LIFO push+pop replaces the top entry
    l_swe = 1; l_swd = 32'h0000AAAA; tick();
    l_sre = 1; l_swd = 32'h0000BBBB;
    q_l.push_back(rd_t'{SRC_SEQ, 4'd0, 32'h0000AAAA}); tick();
    l_swe = 0;
    chk("l_cnt_pushpop", l_cnt, 1);
    q_l.push_back(rd_t'{SRC_SEQ, 4'd0, 32'h0000BBBB}); tick();
    l_sre = 0;
    chk("l_empty_final", l_empty, 1);

    // Arbitration: pop beats random read, random read retried next cycle
    f_swe = 1; f_swd = 32'hD0D0D0D0;
    f_rwe = 1; f_rwa = 4'd5; f_rwd = 32'h55555555; tick();
    f_swe = 0; f_rwe = 0;
    chk("f_drop_nocollide", f_drop, 0);
    f_sre = 1; f_rre = 1; f_rra = 4'd5; #1;
    chk("f_ran_ready_blocked", f_rdy, 0);
    q_f.push_back(rd_t'{SRC_SEQ, 4'd2, 32'hD0D0D0D0}); tick();
    f_sre = 0; #1;
    chk("f_ran_ready_free", f_rdy, 1);
    q_f.push_back(rd_t'{SRC_RAN, 4'd5, 32'h55555555}); tick();
    f_rre = 0;

    // Push and random write to the same address: push wins
    f_swe = 1; f_swd = 32'hE0E0E0E0;
    f_rwe = 1; f_rwa = 4'd3; f_rwd = 32'hBADBAD00; tick();
    f_swe = 0; f_rwe = 0;
    chk("f_drop_pulse", f_drop, 1);
    f_rre = 1; f_rra = 4'd3;
    q_f.push_back(rd_t'{SRC_RAN, 4'd3, 32'hE0E0E0E0}); tick();
    f_rre = 0;
    chk("f_drop_clear", f_drop, 0);
    f_sre = 1;
    q_f.push_back(rd_t'{SRC_SEQ, 4'd3, 32'hE0E0E0E0}); tick();
    f_sre = 0;

    // Fill to DEPTH (pointers start at 4), then overflow
    for (int i = 0; i < int'(DEPTH); i++) begin
      f_swe = 1; f_swd = 32'h100 + i; tick();
    end
    chk("f_full", f_full, 1);
    chk("f_cnt_depth", f_cnt, DEPTH);
    chk("f_ovf_before", f_ovf, 0);
    f_swd = 32'hDEAD; tick();
    f_swe = 0;
    chk("f_ovf_set", f_ovf, 1);
    chk("f_cnt_after_ovf", f_cnt, DEPTH);
    // Push+pop while full
    f_swe = 1; f_sre = 1; f_swd = 32'h200;
    q_f.push_back(rd_t'{SRC_SEQ, 4'd4, 32'h100}); tick();
    f_swe = 0; f_sre = 0;
    chk("f_cnt_full_pushpop", f_cnt, DEPTH);
    // Drain
    f_sre = 1;
    for (int i = 1; i <= int'(DEPTH); i++) begin
      if (i < int'(DEPTH))
        q_f.push_back(rd_t'{SRC_SEQ, AW'((4 + i) % 16), 32'h100 + i});
      else
        q_f.push_back(rd_t'{SRC_SEQ, 4'd4, 32'h200});
      tick();
    end
    f_sre = 0;
    chk("f_empty_drained", f_empty, 1);
    chk("f_udf_before", f_udf, 0);
    // Pop while empty: no r_valid, udf sticky
    f_sre = 1; tick();
    f_sre = 0;
    chk("f_udf_set", f_udf, 1);
    chk("f_ovf_sticky", f_ovf, 1);
    // Push+pop while empty: push proceeds at addr 5, pop ignored
    f_swe = 1; f_sre = 1; f_swd = 32'h300; tick();
    f_swe = 0; f_sre = 0;
    chk("f_cnt_pushpop_empty", f_cnt, 1);
    f_sre = 1;
    q_f.push_back(rd_t'{SRC_SEQ, 4'd5, 32'h300}); tick();
    f_sre = 0;

`ifdef INEXRECUR_FIELD_WE_EN
    // Per-field random write
    f_rwe = 1; f_rwa = 4'd7; f_rwd = 32'h11223344; f_fe = 4'b1111; tick();
    f_rwd = 32'hAABBCCDD; f_fe = 4'b0011; tick();
    f_rwe = 0; f_fe = 4'b1111;
    f_rre = 1; f_rra = 4'd7;
    q_f.push_back(rd_t'{SRC_RAN, 4'd7, 32'h1122CCDD}); tick();
    f_rre = 0;
`endif

    // Reset while a read is in flight
    tick();
    f_swe = 1; f_swd = 32'h77; tick();
    f_swe = 0; f_sre = 1;
    @(posedge clk); #2;
    rst_n = 1'b0; f_sre = 0; #1;
    chk("f_rvalid_midreset", f_rv, 0);
    chk("f_cnt_midreset", f_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    f_swe = 1; f_swd = 32'h88; tick();
    f_swe = 0; f_sre = 1;
    q_f.push_back(rd_t'{SRC_SEQ, 4'd0, 32'h88}); tick();
    f_sre = 0;

    repeat (3) tick();
    chk("f_sb_drained", q_f.size(), 0);
    chk("l_sb_drained", q_l.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
